meta_info_reader: RTL and testbench



---
 rtl/meta_info_reader.sv | 121 ++++++++++++
 tb/tb_meta_info_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_info_reader.sv
// Steps the meta-info ROM character index for one project, waits SETTLE_CYCLES per address,
// and streams each byte over valid/ready until a NUL byte or MAX_CHARS characters.
module meta_info_reader #(
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_CHARS     = 63,
    parameter int IDX_W         = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] proj_sel,
    output logic [IDX_W-1:0] rom_proj_idx,
    output logic [IDX_W-1:0] rom_chr_idx,
    input  logic [7:0]       rom_chr,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] char_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(MAX_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EMIT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
    logic [IDX_W-1:0] proj_nxt, chr_nxt, count_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            rom_proj_idx <= '0;
            rom_chr_idx  <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            char_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_cnt_nxt;
            rom_proj_idx <= proj_nxt;
            rom_chr_idx  <= chr_nxt;
            out_data     <= data_nxt;
            out_valid    <= valid_nxt;
            char_count   <= count_nxt;
            // busy/done are registered copies of the state being entered
            busy         <= (state_nxt != IDLE);
            done         <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        proj_nxt       = rom_proj_idx;
        chr_nxt        = rom_chr_idx;
        count_nxt      = char_count;
        data_nxt       = out_data;
        valid_nxt      = out_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    proj_nxt       = proj_sel;
                    chr_nxt        = '0;
                    count_nxt      = '0;
                    settle_cnt_nxt = '0;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                settle_cnt_nxt = settle_cnt + 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (rom_chr == 8'h00) begin
                    state_nxt = DONE;
                end else begin
                    data_nxt  = rom_chr;
                    valid_nxt = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = char_count + 1'b1;
                    if (rom_chr_idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        chr_nxt        = rom_chr_idx + 1'b1;
                        settle_cnt_nxt = '0;
                        state_nxt      = SETTLE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_meta_info_reader.sv
// Directed bench for meta_info_reader: a behavioural ROM drives rom_chr, expected bytes are
// queued at each start and popped by a monitor on every out_valid/out_ready handshake.
module tb_meta_info_reader;

    localparam int IDX_W = 6;
    localparam int MAX_CHARS = 63;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] proj_sel;
    logic [IDX_W-1:0] rom_proj_idx;
    logic [IDX_W-1:0] rom_chr_idx;
    logic [7:0]       rom_chr;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] char_count;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    bit         valid_seen = 0;
    bit         idx_over = 0;
    logic [7:0] sb[$];
    int         hs_cyc[$];
    int         done_cyc[$];

    meta_info_reader #(.SETTLE_CYCLES(8), .MAX_CHARS(MAX_CHARS), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .start(start), .proj_sel(proj_sel),
        .rom_proj_idx(rom_proj_idx), .rom_chr_idx(rom_chr_idx), .rom_chr(rom_chr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .char_count(char_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [IDX_W-1:0] p, input logic [IDX_W-1:0] i);
        logic [7:0] c;
        c = 8'h00;
        if (p == 6'd5) begin
            if (i == 6'd0) c = 8'h48;
            else if (i == 6'd1) c = 8'h49;
        end else if (p == 6'd7) begin
            if (i < 6'd63) c = 8'h41;
        end else if (p == 6'd9) begin
            if (i < 6'd2) c = 8'h5A;
        end
        return c;
    endfunction

    assign rom_chr = rom(rom_proj_idx, rom_chr_idx);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (out_valid) valid_seen = 1;
            if (rom_chr_idx > 6'(MAX_CHARS - 1)) idx_over = 1;
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) check("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
                else check("out_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_msg(input logic [IDX_W-1:0] p);
        for (int i = 0; i < MAX_CHARS; i++) begin
            logic [7:0] c;
            c = rom(p, IDX_W'(i));
            if (c == 8'h00) break;
            sb.push_back(c);
        end
    endtask

    // Returns having passed the accepting edge, 1ns after it.
    task automatic do_start(input logic [IDX_W-1:0] p);
        push_msg(p);
        start = 1'b1;
        proj_sel = p;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        check(tag, {31'h0, out_valid}, 32'h1);
    endtask

    task automatic wait_done(input string tag, input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin tick(); n++; end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    initial begin
        int n;
        int d0;
        reset = 1'b1; start = 1'b0; proj_sel = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_out_data", {24'h0, out_data}, 0);
        check("rst_char_count", {26'h0, char_count}, 0);
        check("rst_rom_proj", {26'h0, rom_proj_idx}, 0);
        check("rst_rom_chr", {26'h0, rom_chr_idx}, 0);
        reset = 1'b0;
        tick();

        // "HI": first valid 9 edges after accept, 10-cycle spacing
        out_ready = 1'b1;
        hs_cyc.delete(); done_cnt = 0;
        do_start(6'd5);
        check("busy_after_start", {31'h0, busy}, 1);
        wait_valid("hi_first_valid", n);
        check("hi_first_latency", n, 9);
        wait_done("hi_done", 100, n);
        tick();
        check("hi_done_pulses", done_cnt, 1);
        check("hi_char_count", {26'h0, char_count}, 2);
        check("hi_rom_chr_idx", {26'h0, rom_chr_idx}, 2);  // NUL was read at index 2
        check("hi_rom_proj", {26'h0, rom_proj_idx}, 5);
        check("hi_hs_count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) check("hi_spacing", hs_cyc[1] - hs_cyc[0], 10);
        check("hi_sb_empty", sb.size(), 0);
        check("hi_idle", {31'h0, busy}, 0);

        // Empty message
        valid_seen = 0; done_cnt = 0;
        do_start(6'd0);
        wait_done("empty_done", 100, n);
        check("empty_done_latency", n, 9);
        check("empty_char_count", {26'h0, char_count}, 0);
        tick(); tick();
        check("empty_no_valid", {31'h0, valid_seen}, 0);
        check("empty_done_pulses", done_cnt, 1);

        // 63 bytes with no NUL: stops at MAX_CHARS
        idx_over = 0; hs_cyc.delete(); done_cnt = 0;
        do_start(6'd7);
        wait_done("max_done", 2000, n);
        check("max_char_count", {26'h0, char_count}, 63);
        check("max_rom_chr_idx", {26'h0, rom_chr_idx}, 62);
        check("max_hs_count", hs_cyc.size(), 63);
        tick(); tick();
        check("max_idx_never_63", {31'h0, idx_over}, 0);
        check("max_done_pulses", done_cnt, 1);
        check("max_sb_empty", sb.size(), 0);

        // Stall 20 cycles on the first character
        out_ready = 1'b0; done_cnt = 0;
        do_start(6'd5);
        wait_valid("stall_valid", n);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_valid_hold", {31'h0, out_valid}, 1);
            check("stall_data_hold", {24'h0, out_data}, 32'h48);
        end
        check("stall_sb_untouched", sb.size(), 2);
        out_ready = 1'b1;
        wait_done("stall_done", 100, n);
        tick();
        check("stall_char_count", {26'h0, char_count}, 2);
        check("stall_sb_empty", sb.size(), 0);
        check("stall_done_pulses", done_cnt, 1);

        // start while busy is ignored
        done_cnt = 0;
        do_start(6'd5);
        tick(); tick();
        start = 1'b1; proj_sel = 6'd9;
        tick();
        start = 1'b0;
        check("ign_rom_proj", {26'h0, rom_proj_idx}, 5);
        wait_done("ign_done", 100, n);
        check("ign_rom_proj_end", {26'h0, rom_proj_idx}, 5);
        check("ign_char_count", {26'h0, char_count}, 2);
        tick();
        check("ign_done_pulses", done_cnt, 1);
        check("ign_sb_empty", sb.size(), 0);

        // Reset during EMIT of the second character
        out_ready = 1'b0; done_cnt = 0;
        do_start(6'd5);
        wait_valid("rst_first_valid", n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("rst_second_valid", n);
        check("rst_second_data", {24'h0, out_data}, 32'h49);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out_valid", {31'h0, out_valid}, 0);
        check("mid_rst_char_count", {26'h0, char_count}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_done", {31'h0, done}, 0);
        sb.delete();
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) tick();
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_still_idle", {31'h0, busy}, 0);
        out_ready = 1'b1;
        do_start(6'd5);
        wait_done("post_rst_done", 100, n);
        check("post_rst_char_count", {26'h0, char_count}, 2);
        tick();
        check("post_rst_sb_empty", sb.size(), 0);

        // start held high: a new read begins on the first IDLE cycle
        done_cyc.delete();
        start = 1'b1; proj_sel = 6'd0;
        for (int i = 0; i < 30; i++) tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("held_start_dones", done_cyc.size() >= 2, 1);
        if (done_cyc.size() >= 2) check("held_start_period", done_cyc[1] - done_cyc[0], 11);
        check("held_start_idle", {31'h0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
